block_sync_rx: RTL and testbench
================================

Name: block_sync_rx

Overview:
- Clause 49 style block-lock controller for the 64b/66b receive path.
- Sits after the rx gearbox. It checks the 2-bit sync header of each valid 66-bit block and decides whether block lock is held.
- When lock is not acquired, or is lost, it pulses the gearbox slip request to move block alignment by one bit.
- It sequences the gearbox and gives the descrambler/decoder a qualified lock indication.

Parameters:
- HEAD_W, 2, sync header width.
- SH_CNT_MAX, 64, headers per test window.
- INVLD_MAX, 16, invalid headers in one window that drop an established lock.
- SLIP_BLANK, 2, valid blocks discarded after a slip before testing resumes (gearbox settle time); legal range 0..7.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- lock_v_i  in  1  PMA signal/CDR lock; low forces reacquisition.
- valid_i  in  1  gearbox output block valid this cycle.
- head_i  in  HEAD_W  sync header of the current block.
- slip_v_o  out  1  one-cycle slip request to the gearbox.
- block_lock_o  out  1  block lock established.
- sh_invld_cnt_o  out  5  current window invalid-header count (debug).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state INIT, sh_cnt=0, invld_cnt=0, blank_cnt=0, block_lock_o=0, slip_v_o=0.
- Header check: sh_valid = head_i[1] ^ head_i[0]. 01 and 10 are valid; 00 and 11 are invalid. head_i is only evaluated when valid_i=1.
- Counter widths:
  - sh_cnt is clog2(SH_CNT_MAX)+1 bits.
  - invld_cnt is 5 bits and saturates at INVLD_MAX.
  - blank_cnt is 3 bits.
- All outputs are registered or Moore; there are no combinational paths from input to output.
- State INIT: counters are cleared. Goes to TEST on the first cycle with lock_v_i=1.
- State TEST, on each cycle with valid_i=1:
  - sh_cnt increments. If sh_valid=0, invld_cnt also increments.
  - Not locked, invalid header: go to SLIP.
  - Not locked, the header completes SH_CNT_MAX consecutive valid headers: block_lock_o=1 from the next cycle; counters clear; stay in TEST.
  - Locked, invld_cnt reaches INVLD_MAX: block_lock_o=0 from the next cycle; go to SLIP.
  - Locked, the header completes the window with invld_cnt<INVLD_MAX: counters clear; lock is kept.
  - If the window end and the INVLD_MAX-th invalid header coincide, the invalid threshold wins and the block goes to SLIP.
- TEST cycles with valid_i=0: no counter change and no state change.
- State SLIP:
  - Lasts exactly one cycle with slip_v_o=1.
  - Counters clear and blank_cnt loads SLIP_BLANK.
  - Next state is BLANK, or TEST if SLIP_BLANK=0.
- Slip latency: an invalid header sampled at edge N causes slip_v_o=1 in the cycle after edge N, for exactly one cycle. A second slip cannot occur earlier than SLIP_BLANK+1 valid blocks later.
- State BLANK: blank_cnt decrements on each valid_i=1 cycle and the headers are ignored. Goes to TEST when blank_cnt reaches 0.
- lock_v_i=0 in any state:
  - Next state is INIT; counters clear; block_lock_o=0 after that edge.
  - Takes priority over every other transition, including a pending slip.
  - slip_v_o is not asserted.
- reset mid-operation: same effect as lock_v_i=0, and reset also dominates lock_v_i.
- sh_invld_cnt_o mirrors invld_cnt and is 0 outside TEST.
- The block never asserts slip_v_o while block_lock_o=1 in the same cycle.

Test Plan:
- Acquire lock: reset, lock_v_i=1, then 64 valid blocks with head_i=01 → block_lock_o rises the cycle after the 64th block; slip_v_o never asserts.
- Slip on bad header: unlocked, head_i=00 on the 10th valid block → slip_v_o=1 for exactly one cycle, and the next 2 valid blocks are ignored even if invalid. Follow with 64 blocks of head_i=10 → lock acquired.
- Lock tolerance: locked, 15 invalid headers (11) spread within one 64-block window → block_lock_o stays 1, counters clear at window end, and sh_invld_cnt_o returns to 0.
- Lock loss: locked, 16 invalid headers within a window → block_lock_o=0 and a single slip_v_o pulse the cycle after the 16th. Also test 16th invalid header on the 64th block → SLIP is taken.
- Gaps and drop: valid_i toggling 1/0 → only valid cycles counted; lock is acquired after 64 valid, not 64 total, cycles. Then lock_v_i=0 mid-window → INIT next cycle, block_lock_o=0, no slip.
- Reset during SLIP/BLANK: assert reset with slip_v_o=1 → all outputs 0 the next cycle, and the block reacquires normally after release.

Source files
------------

// File: rtl/block_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : block_sync_rx
// Description : 64b/66b receive block-lock controller. It checks the 2-bit
//               sync header of each valid block from the rx gearbox and
//               decides whether block lock is held. While unlocked, or after
//               lock is lost, it pulses a one-bit slip request to the gearbox.
//               The descrambler/decoder receives a qualified lock flag.
// Ports       : clk            - clock
//               reset          - synchronous, active-high reset
//               lock_v_i       - PMA/CDR lock; low forces reacquisition
//               valid_i        - gearbox block valid this cycle
//               head_i         - sync header of the current block
//               slip_v_o       - one-cycle slip request to the gearbox
//               block_lock_o   - block lock established
//               sh_invld_cnt_o - invalid headers in the current window (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module block_sync_rx #(
    parameter int HEAD_W     = 2,
    parameter int SH_CNT_MAX = 64,
    parameter int INVLD_MAX  = 16,
    parameter int SLIP_BLANK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lock_v_i,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    output logic              slip_v_o,
    output logic              block_lock_o,
    output logic [4:0]        sh_invld_cnt_o
);

    localparam int               c_SH_W    = $clog2(SH_CNT_MAX) + 1;
    localparam logic [c_SH_W-1:0] c_SH_MAX  = c_SH_W'(SH_CNT_MAX);
    localparam logic [4:0]        c_INV_MAX = 5'(INVLD_MAX);
    localparam logic [2:0]        c_BLANK   = 3'(SLIP_BLANK);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TEST  = 2'd1,
        S_SLIP  = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [c_SH_W-1:0]   r_sh_cnt,     w_sh_cnt_nxt;
    logic [4:0]          r_invld_cnt,  w_invld_cnt_nxt;
    logic [2:0]          r_blank_cnt,  w_blank_cnt_nxt;
    logic                r_block_lock, w_block_lock_nxt;

    logic                w_sh_valid;
    logic [c_SH_W-1:0]   w_sh_cnt_inc;
    logic [4:0]          w_invld_inc;

    assign w_sh_valid   = head_i[1] ^ head_i[0];
    assign w_sh_cnt_inc = r_sh_cnt + 1'b1;
    // Invalid count saturates at the threshold so it can never wrap.
    assign w_invld_inc  = (!w_sh_valid && (r_invld_cnt != c_INV_MAX))
                          ? r_invld_cnt + 5'd1 : r_invld_cnt;

    always_comb begin
        w_state_nxt      = r_state;
        w_sh_cnt_nxt     = r_sh_cnt;
        w_invld_cnt_nxt  = r_invld_cnt;
        w_blank_cnt_nxt  = r_blank_cnt;
        w_block_lock_nxt = r_block_lock;

        case (r_state)
            S_INIT: begin
                w_sh_cnt_nxt    = '0;
                w_invld_cnt_nxt = '0;
                w_blank_cnt_nxt = '0;
                w_state_nxt     = S_TEST;
            end

            S_TEST: begin
                if (valid_i) begin
                    w_sh_cnt_nxt    = w_sh_cnt_inc;
                    w_invld_cnt_nxt = w_invld_inc;
                    if (!r_block_lock) begin
                        // While hunting, a single bad header moves alignment.
                        if (!w_sh_valid) begin
                            w_state_nxt = S_SLIP;
                        end else if (w_sh_cnt_inc == c_SH_MAX) begin
                            w_block_lock_nxt = 1'b1;
                            w_sh_cnt_nxt     = '0;
                            w_invld_cnt_nxt  = '0;
                        end
                    end else begin
                        // Threshold is tested before window end so a
                        // coincident 16th bad header still drops lock.
                        if (w_invld_inc >= c_INV_MAX) begin
                            w_block_lock_nxt = 1'b0;
                            w_state_nxt      = S_SLIP;
                        end else if (w_sh_cnt_inc == c_SH_MAX) begin
                            w_sh_cnt_nxt    = '0;
                            w_invld_cnt_nxt = '0;
                        end
                    end
                end
            end

            S_SLIP: begin
                w_sh_cnt_nxt    = '0;
                w_invld_cnt_nxt = '0;
                w_blank_cnt_nxt = c_BLANK;
                w_state_nxt     = (c_BLANK == 3'd0) ? S_TEST : S_BLANK;
            end

            S_BLANK: begin
                // Headers are ignored while the gearbox settles.
                if (r_blank_cnt == 3'd0) begin
                    w_state_nxt = S_TEST;
                end else if (valid_i) begin
                    w_blank_cnt_nxt = r_blank_cnt - 3'd1;
                    if (r_blank_cnt == 3'd1) begin
                        w_state_nxt = S_TEST;
                    end
                end
            end

            default: begin
                w_state_nxt = S_INIT;
            end
        endcase

        // Loss of PMA lock overrides every transition, including a slip.
        if (!lock_v_i) begin
            w_state_nxt      = S_INIT;
            w_sh_cnt_nxt     = '0;
            w_invld_cnt_nxt  = '0;
            w_blank_cnt_nxt  = '0;
            w_block_lock_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_INIT;
            r_sh_cnt     <= '0;
            r_invld_cnt  <= '0;
            r_blank_cnt  <= '0;
            r_block_lock <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sh_cnt     <= w_sh_cnt_nxt;
            r_invld_cnt  <= w_invld_cnt_nxt;
            r_blank_cnt  <= w_blank_cnt_nxt;
            r_block_lock <= w_block_lock_nxt;
        end
    end

    // Lock is always cleared on entry to SLIP, so slip and lock never overlap.
    assign slip_v_o       = (r_state == S_SLIP);
    assign block_lock_o   = r_block_lock;
    assign sh_invld_cnt_o = (r_state == S_TEST) ? r_invld_cnt : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_block_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_sync_rx
// Description : Self-checking bench for block_sync_rx. A behavioural model
//               predicts the outputs for every driven cycle; predictions are
//               queued and compared once the DUT has clocked the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_sync_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       lock_v_i;
    logic       valid_i;
    logic [1:0] head_i;
    logic       slip_v_o;
    logic       block_lock_o;
    logic [4:0] sh_invld_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_slip  = 0;

    typedef struct packed {
        logic       slip;
        logic       lock;
        logic [4:0] inv;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state: 0 INIT, 1 TEST, 2 SLIP, 3 BLANK
    int m_state = 0;
    int m_sh    = 0;
    int m_inv   = 0;
    int m_blank = 0;
    bit m_lock  = 0;

    block_sync_rx #(
        .HEAD_W     (2),
        .SH_CNT_MAX (64),
        .INVLD_MAX  (16),
        .SLIP_BLANK (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lock_v_i       (lock_v_i),
        .valid_i        (valid_i),
        .head_i         (head_i),
        .slip_v_o       (slip_v_o),
        .block_lock_o   (block_lock_o),
        .sh_invld_cnt_o (sh_invld_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit lv, input bit v, input logic [1:0] h);
        bit bad;
        bad = (h == 2'b00) || (h == 2'b11);
        if (r || !lv) begin
            m_state = 0; m_sh = 0; m_inv = 0; m_blank = 0; m_lock = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (v) begin
                    m_sh++;
                    if (bad && m_inv < 16) m_inv++;
                    if (!m_lock) begin
                        if (bad) m_state = 2;
                        else if (m_sh == 64) begin m_lock = 1; m_sh = 0; m_inv = 0; end
                    end else begin
                        if (m_inv == 16) begin m_lock = 0; m_state = 2; end
                        else if (m_sh == 64) begin m_sh = 0; m_inv = 0; end
                    end
                end
                2: begin
                    m_sh = 0; m_inv = 0; m_blank = 2;
                    m_state = 3;
                end
                default: if (v) begin
                    m_blank--;
                    if (m_blank == 0) m_state = 1;
                end
            endcase
        end
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic drive(input bit r, input bit lv, input bit v, input logic [1:0] h);
        exp_t e;
        reset    = r;
        lock_v_i = lv;
        valid_i  = v;
        head_i   = h;
        model_step(r, lv, v, h);
        e.slip = (m_state == 2);
        e.lock = m_lock;
        e.inv  = (m_state == 1) ? 5'(m_inv) : 5'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("slip_v_o", 32'(slip_v_o), 32'(e.slip));
        check("block_lock_o", 32'(block_lock_o), 32'(e.lock));
        check("sh_invld_cnt_o", 32'(sh_invld_cnt_o), 32'(e.inv));
        check("slip_with_lock", 32'(slip_v_o & block_lock_o), 32'd0);
        if (slip_v_o) n_slip++;
    endtask

    task automatic good_blocks(input int n, input logic [1:0] h);
        for (int i = 0; i < n; i++) drive(0, 1, 1, h);
    endtask

    initial begin
        // Reset
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 2'b00);
        check("reset_lock", 32'(block_lock_o), 32'd0);
        check("reset_slip", 32'(slip_v_o), 32'd0);
        check("reset_inv", 32'(sh_invld_cnt_o), 32'd0);

        // Acquire lock: INIT->TEST, then 64 good headers
        n_slip = 0;
        drive(0, 1, 0, 2'b01);
        good_blocks(63, 2'b01);
        check("acq_before_64", 32'(block_lock_o), 32'd0);
        drive(0, 1, 1, 2'b01);
        check("acq_after_64", 32'(block_lock_o), 32'd1);
        check("acq_no_slip", 32'(n_slip), 32'd0);

        // Slip on 10th block while unlocked
        drive(0, 0, 0, 2'b01);
        drive(0, 1, 0, 2'b01);
        n_slip = 0;
        good_blocks(9, 2'b01);
        drive(0, 1, 1, 2'b00);
        check("slip_pulse", 32'(slip_v_o), 32'd1);
        drive(0, 1, 0, 2'b01);
        check("slip_one_cycle", 32'(slip_v_o), 32'd0);
        good_blocks(2, 2'b11);   // blanked, must not slip
        good_blocks(64, 2'b10);
        check("slip_reacq_lock", 32'(block_lock_o), 32'd1);
        check("slip_count", 32'(n_slip), 32'd1);

        // Tolerance: 15 bad headers within a window keep lock
        n_slip = 0;
        for (int i = 0; i < 64; i++)
            drive(0, 1, 1, ((i % 4) == 0 && i < 60) ? 2'b11 : 2'b01);
        check("tol_lock", 32'(block_lock_o), 32'd1);
        check("tol_inv_clear", 32'(sh_invld_cnt_o), 32'd0);
        check("tol_no_slip", 32'(n_slip), 32'd0);

        // Loss: 16 bad headers at window start
        for (int i = 0; i < 16; i++) drive(0, 1, 1, 2'b11);
        check("loss_slip", 32'(slip_v_o), 32'd1);
        check("loss_lock", 32'(block_lock_o), 32'd0);
        drive(0, 1, 0, 2'b01);
        good_blocks(2, 2'b01);
        good_blocks(64, 2'b01);
        check("loss_reacq", 32'(block_lock_o), 32'd1);
        // 16th bad header coincides with window end
        good_blocks(48, 2'b01);
        for (int i = 0; i < 15; i++) drive(0, 1, 1, 2'b00);
        check("edge_still_locked", 32'(block_lock_o), 32'd1);
        drive(0, 1, 1, 2'b00);
        check("edge_slip", 32'(slip_v_o), 32'd1);
        check("edge_lock", 32'(block_lock_o), 32'd0);

        // Gaps: only valid cycles count toward lock
        drive(0, 0, 0, 2'b01);
        drive(0, 1, 0, 2'b01);
        for (int i = 0; i < 126; i++) drive(0, 1, (i % 2) == 0, 2'b01);
        check("gap_not_yet", 32'(block_lock_o), 32'd0);
        drive(0, 1, 1, 2'b01);
        check("gap_lock", 32'(block_lock_o), 32'd1);
        good_blocks(10, 2'b01);
        n_slip = 0;
        drive(0, 0, 1, 2'b00);
        check("drop_lock", 32'(block_lock_o), 32'd0);
        drive(0, 1, 0, 2'b01);
        check("drop_no_slip", 32'(n_slip), 32'd0);

        // Reset while slip is asserted
        drive(0, 1, 1, 2'b00);
        check("rst_slip_on", 32'(slip_v_o), 32'd1);
        drive(1, 1, 1, 2'b01);
        check("rst_slip_off", 32'(slip_v_o), 32'd0);
        check("rst_lock_off", 32'(block_lock_o), 32'd0);
        drive(0, 1, 0, 2'b01);
        good_blocks(64, 2'b01);
        check("rst_reacq", 32'(block_lock_o), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] h;
            h = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 1) * 3)
                                              : 2'($urandom_range(1, 2));
            drive($urandom_range(0, 499) == 0, $urandom_range(0, 299) != 0,
                  $urandom_range(0, 3) != 0, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
